// File: rtl/cp_remove_pkg.sv
// Shared widths and FSM encoding for the cyclic-prefix removal block.
package cp_remove_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int WORD_W     = 32;
  localparam int N_SAMPLES  = 8;
  localparam int N_WORDS    = 9;
  localparam int BIT_CNT_W  = 6;
  localparam int WORD_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CP   = 2'd1,
    ST_DATA = 2'd2
  } state_t;

endpackage

// File: rtl/cp_remove_if.sv
// Serial input and recovered-symbol output bundle of cp_remove.
interface cp_remove_if;
  import cp_remove_pkg::*;

  logic                serialIn;
  logic                inValid;
  logic                sync;
  logic [SAMPLE_W-1:0] out0R, out0I, out1R, out1I, out2R, out2I, out3R, out3I;
  logic [SAMPLE_W-1:0] out4R, out4I, out5R, out5I, out6R, out6I, out7R, out7I;
  logic                outValid;
  logic                cpError;
  logic                busy;

  modport master (
    output serialIn, inValid, sync,
    input  out0R, out0I, out1R, out1I, out2R, out2I, out3R, out3I,
    input  out4R, out4I, out5R, out5I, out6R, out6I, out7R, out7I,
    input  outValid, cpError, busy
  );

  modport slave (
    input  serialIn, inValid, sync,
    output out0R, out0I, out1R, out1I, out2R, out2I, out3R, out3I,
    output out4R, out4I, out5R, out5I, out6R, out6I, out7R, out7I,
    output outValid, cpError, busy
  );

endinterface

// File: rtl/cp_remove_shift32.sv
// 32-bit MSB-first serial-to-parallel shifter. The 31 older bits are
// registered and the newest bit comes straight from din, so the complete
// word is available on the very edge that captures its last bit.
import cp_remove_pkg::*;

module cpr_shift32 (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              din,
  output logic [WORD_W-1:0] word
);

  logic [WORD_W-2:0] q;

  // shift one bit in from the LSB side whenever enabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else if (en) q <= {q[WORD_W-3:0], din};
  end

  assign word = {q, din};

endmodule

// File: rtl/cp_remove.sv
// Cyclic-prefix removal: deserialises 9-word symbols, drops the prefix word,
// presents samples 0..7 and flags a prefix that does not copy sample 7.
//
//   state   | meaning
//   IDLE    | waiting for sync; unsynchronised bits are discarded
//   CP      | receiving word 0 (cyclic prefix)
//   DATA    | receiving words 1..8 (samples 0..7)
import cp_remove_pkg::*;

module cp_remove (
  input  logic        clk,
  input  logic        rst,
  cp_remove_if.slave  bus
);

  state_t                  state, state_n;
  logic [BIT_CNT_W-1:0]    bit_cnt, bit_cnt_n;
  logic [WORD_CNT_W-1:0]   word_cnt, word_cnt_n;
  logic                    shift_en, store_cp, store_smp, done;
  logic [WORD_W-1:0]       word_now;
  logic [WORD_W-1:0]       prefix;
  logic [WORD_W-1:0]       smp   [0:N_SAMPLES-2];
  logic [WORD_W-1:0]       out_w [0:N_SAMPLES-1];
  logic [2:0]              slot;
  logic                    out_valid_q, cp_err_q;

  cpr_shift32 u_shift (
    .clk  (clk),
    .rst  (rst),
    .en   (shift_en),
    .din  (bus.serialIn),
    .word (word_now)
  );

  // word 8 never lands in smp; it goes straight to the output on completion
  assign slot = word_cnt[2:0] - 3'd1;

  // state and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      word_cnt <= word_cnt_n;
    end
  end

  // next state, counter advance and word-store strobes
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    word_cnt_n = word_cnt;
    store_cp   = 1'b0;
    store_smp  = 1'b0;
    done       = 1'b0;
    shift_en   = bus.inValid && (bus.sync || (state != ST_IDLE));
    if (bus.inValid) begin
      if (bus.sync) begin
        // sync always restarts: this bit is bit 0 of a fresh prefix
        state_n    = ST_CP;
        bit_cnt_n  = 6'd1;
        word_cnt_n = '0;
      end else if (state != ST_IDLE) begin
        if (bit_cnt == 6'd31) begin
          bit_cnt_n = '0;
          if (state == ST_CP) begin
            store_cp   = 1'b1;
            word_cnt_n = 4'd1;
            state_n    = ST_DATA;
          end else if (word_cnt == 4'd8) begin
            done       = 1'b1;
            word_cnt_n = '0;
            state_n    = ST_CP;
          end else begin
            store_smp  = 1'b1;
            word_cnt_n = word_cnt + 4'd1;
          end
        end else begin
          bit_cnt_n = bit_cnt + 6'd1;
        end
      end
    end
  end

  // word storage, output update and prefix comparison
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prefix      <= '0;
      out_valid_q <= 1'b0;
      cp_err_q    <= 1'b0;
      for (int k = 0; k < N_SAMPLES - 1; k++) smp[k] <= '0;
      for (int k = 0; k < N_SAMPLES; k++) out_w[k] <= '0;
    end else begin
      out_valid_q <= done;
      if (store_cp) prefix <= word_now;
      if (store_smp) smp[slot] <= word_now;
      if (done) begin
        for (int k = 0; k < N_SAMPLES - 1; k++) out_w[k] <= smp[k];
        out_w[N_SAMPLES-1] <= word_now;
        cp_err_q           <= (prefix != word_now);
      end
    end
  end

  assign bus.busy     = (state != ST_IDLE) && ((bit_cnt != '0) || (word_cnt != '0));
  assign bus.outValid = out_valid_q;
  assign bus.cpError  = cp_err_q;

  assign bus.out0R = out_w[0][WORD_W-1:SAMPLE_W];
  assign bus.out0I = out_w[0][SAMPLE_W-1:0];
  assign bus.out1R = out_w[1][WORD_W-1:SAMPLE_W];
  assign bus.out1I = out_w[1][SAMPLE_W-1:0];
  assign bus.out2R = out_w[2][WORD_W-1:SAMPLE_W];
  assign bus.out2I = out_w[2][SAMPLE_W-1:0];
  assign bus.out3R = out_w[3][WORD_W-1:SAMPLE_W];
  assign bus.out3I = out_w[3][SAMPLE_W-1:0];
  assign bus.out4R = out_w[4][WORD_W-1:SAMPLE_W];
  assign bus.out4I = out_w[4][SAMPLE_W-1:0];
  assign bus.out5R = out_w[5][WORD_W-1:SAMPLE_W];
  assign bus.out5I = out_w[5][SAMPLE_W-1:0];
  assign bus.out6R = out_w[6][WORD_W-1:SAMPLE_W];
  assign bus.out6I = out_w[6][SAMPLE_W-1:0];
  assign bus.out7R = out_w[7][WORD_W-1:SAMPLE_W];
  assign bus.out7I = out_w[7][SAMPLE_W-1:0];

endmodule
